// File: rtl/i2c_master_pkg.sv
// Shared types and bus frame constants for the
// arbitrated single-byte I2C master.
package i2c_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    DATA,
    DACK,
    STOP,
    RESP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Bit n of each pattern is the line level in quarter n.
  localparam logic [3:0] START_SDA = 4'b0011;
  localparam logic [3:0] START_SCL = 4'b0111;
  localparam logic [3:0] STOP_SDA  = 4'b1100;
  localparam logic [3:0] STOP_SCL  = 4'b1110;

endpackage

// File: rtl/i2c_master_arb_qtick.sv
// Quarter-period tick generator: pulses qtick every
// QTR_CYC clocks while enabled, and steps a 2-bit index.
module i2c_qtick
  import i2c_master_pkg::*;
#(
  parameter int QTR_CYC = 125,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       qtick,
  output logic [1:0] qidx
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(QTR_CYC - 1);

  logic [CNT_W-1:0] cnt;

  assign qtick = en && (cnt == LAST);

  // Count clocks within a quarter; hold at Q0 when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      qidx <= Q0;
    end else if (!en) begin
      cnt  <= '0;
      qidx <= Q0;
    end else if (qtick) begin
      cnt  <= '0;
      qidx <= qidx + 2'd1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_arb.sv
// Round-robin two-requester I2C master running one
// START/addr/byte/STOP transaction at a time.
module i2c_master_arb
  import i2c_master_pkg::*;
#(
  parameter int QTR_CYC = 125,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        scl,
  inout  wire         sda,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [13:0] req_addr,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack
);

  state_t     state, state_nx;
  logic       qtick;
  logic [1:0] q;
  logic       end_bit, smp;
  logic [1:0] gnt;
  logic       accept;
  logic       last_grant;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       rw_q;
  logic       id_q;
  logic       nack_q;
  logic       sda_oe;
  logic       sda_in;
  logic       bit_scl;

  i2c_qtick #(
    .QTR_CYC (QTR_CYC),
    .CNT_W   (CNT_W)
  ) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != IDLE),
    .qtick (qtick),
    .qidx  (q)
  );

  assign sda       = sda_oe ? 1'b0 : 1'bz;
  assign sda_in    = sda;
  assign end_bit   = qtick && (q == Q3);
  assign smp       = qtick && (q == Q1);
  assign bit_scl   = (q == Q1) || (q == Q2);
  assign accept    = (state == IDLE) && rst_n && (gnt != 2'b00);
  assign req_ready = accept ? gnt : 2'b00;
  assign busy      = (state != IDLE) || accept;
  assign rsp_valid = (state == RESP);

  // Round-robin pick: on a tie, favour the other requester.
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      req_valid == 2'b11: gnt = last_grant ? 2'b01 : 2'b10;
      req_valid == 2'b01: gnt = 2'b01;
      req_valid == 2'b10: gnt = 2'b10;
      default:            gnt = 2'b00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Frame sequencing and per-quarter bus levels.
  always_comb begin
    state_nx = state;
    scl      = 1'b1;
    sda_oe   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        scl    = START_SCL[q];
        sda_oe = !START_SDA[q];
        if (end_bit) state_nx = ADDR;
      end
      ADDR: begin
        scl    = bit_scl;
        sda_oe = !sh[7];
        if (end_bit && bit_cnt == 3'd7) state_nx = AACK;
      end
      AACK: begin
        scl = bit_scl;
        if (end_bit) state_nx = nack_q ? STOP : DATA;
      end
      DATA: begin
        scl    = bit_scl;
        sda_oe = !rw_q && !sh[7];
        if (end_bit && bit_cnt == 3'd7) state_nx = DACK;
      end
      DACK: begin
        scl = bit_scl;
        if (end_bit) state_nx = STOP;
      end
      STOP: begin
        scl    = STOP_SCL[q];
        sda_oe = !STOP_SDA[q];
        if (end_bit) state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture request, shift bits, sample ACKs and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      rw_q       <= 1'b0;
      sh         <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      nack_q     <= 1'b0;
      bit_cnt    <= '0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_nack   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= gnt[1];
        id_q       <= gnt[1];
        rw_q       <= req_rw[gnt[1]];
        sh         <= gnt[1] ? {req_addr[13:7], req_rw[1]}
                             : {req_addr[6:0], req_rw[0]};
        wdata_q    <= gnt[1] ? req_wdata[15:8] : req_wdata[7:0];
        rdata_q    <= '0;
        nack_q     <= 1'b0;
        bit_cnt    <= '0;
      end
      if (smp) begin
        unique case (state)
          AACK: nack_q <= sda_in;
          DATA: if (rw_q) rdata_q <= {rdata_q[6:0], sda_in};
          DACK: if (!rw_q && sda_in) nack_q <= 1'b1;
          default: ;
        endcase
      end
      if (end_bit && (state == ADDR || state == DATA)) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (state == ADDR && bit_cnt == 3'd7) sh <= wdata_q;
        else                                  sh <= {sh[6:0], 1'b0};
      end
      if (end_bit && state == STOP) begin
        rsp_id    <= id_q;
        rsp_rdata <= rdata_q;
        rsp_nack  <= nack_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_arb.sv
// Self-checking bench: two DUTs (QTR_CYC 4 and 2) on one
// shared SDA line with a behavioural IO-extender at 0x27.
module tb_i2c_master_arb;

  localparam int QA = 4;
  localparam int QB = 2;

  typedef struct {
    bit       id;
    bit [6:0] addr;
    bit       rw;
    bit [7:0] wdata;
    bit [7:0] mem;
    bit [7:0] e_rdata;
    bit       e_nack;
    bit [7:0] e_abyte;
    bit       e_aack;
    bit [7:0] e_dbyte;
    bit       e_dack;
    int       qtrs;
  } vec_t;

  typedef struct {
    bit       id;
    bit [7:0] rdata;
    bit       nack;
    int       lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          sel = 1'b0;
  logic [1:0]  rvld = 2'b00;
  logic [13:0] raddr = '0;
  logic [1:0]  rrw = 2'b00;
  logic [15:0] rwd = '0;

  wire         sda;
  logic        s_oe = 1'b0;
  pullup (sda);
  assign sda = s_oe ? 1'b0 : 1'bz;

  logic [1:0] rv_a, rv_b, rdy_a, rdy_b, rdy_m;
  logic       scl_a, scl_b, scl_m;
  logic       busy_a, busy_b, busy_m;
  logic       vld_a, vld_b, vld_m;
  logic       id_a, id_b, id_m;
  logic [7:0] rd_a, rd_b, rd_m;
  logic       nk_a, nk_b, nk_m;

  assign rv_a   = sel ? 2'b00 : rvld;
  assign rv_b   = sel ? rvld : 2'b00;
  assign rdy_m  = sel ? rdy_b : rdy_a;
  assign scl_m  = sel ? scl_b : scl_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign vld_m  = sel ? vld_b : vld_a;
  assign id_m   = sel ? id_b : id_a;
  assign rd_m   = sel ? rd_b : rd_a;
  assign nk_m   = sel ? nk_b : nk_a;

  i2c_master_arb #(.QTR_CYC(QA), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .scl(scl_a), .sda(sda),
    .req_valid(rv_a), .req_ready(rdy_a), .req_addr(raddr),
    .req_rw(rrw), .req_wdata(rwd), .busy(busy_a),
    .rsp_valid(vld_a), .rsp_id(id_a), .rsp_rdata(rd_a),
    .rsp_nack(nk_a)
  );

  i2c_master_arb #(.QTR_CYC(QB), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .scl(scl_b), .sda(sda),
    .req_valid(rv_b), .req_ready(rdy_b), .req_addr(raddr),
    .req_rw(rrw), .req_wdata(rwd), .busy(busy_b),
    .rsp_valid(vld_b), .rsp_id(id_b), .rsp_rdata(rd_b),
    .rsp_nack(nk_b)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         t_acc = 0;
  int         n_rsp = 0;
  int         rdy_cnt [2];
  bit         gnt_log [$];
  exp_t       exp_q [$];
  exp_t       e;
  logic [8:0] bus_q [$];
  vec_t       vecs [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slave model state
  logic [7:0] mem = 8'h00;
  logic [7:0] curr_data = 8'h00;
  logic [7:0] ssh = 8'h00;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  bit         act = 1'b0;
  bit         match = 1'b0;
  bit         rd = 1'b0;
  int         bn = 0;
  int         byte_i = 0;

  // IO-extender slave at 0x27, sampled on the falling clk edge.
  initial begin
    forever begin
      @(negedge clk);
      if (p_scl && scl_m && p_sda && !sda) begin
        act = 1'b1; bn = -1; byte_i = 0; s_oe = 1'b0;
      end else if (p_scl && scl_m && !p_sda && sda) begin
        act = 1'b0; s_oe = 1'b0;
      end else if (act && !p_scl && scl_m) begin
        if (bn < 8) ssh = {ssh[6:0], sda};
        else        bus_q.push_back({ssh, sda});
      end else if (act && p_scl && !scl_m) begin
        bn++;
        if (bn == 8) begin
          if (byte_i == 0) begin
            match = (ssh[7:1] == 7'h27);
            rd    = ssh[0];
            s_oe  = match;
          end else if (!rd && match) begin
            curr_data = ssh;
            s_oe      = 1'b1;
          end else begin
            s_oe = 1'b0;
          end
        end else if (bn == 9) begin
          bn = 0;
          byte_i++;
          s_oe = 1'b0;
          if (match && rd && byte_i == 1) s_oe = !mem[7];
        end else if (match && rd && byte_i == 1 && bn > 0) begin
          s_oe = !mem[3'(7 - bn)];
        end
      end
      p_scl = scl_m;
      p_sda = sda;
    end
  end

  bit prev_v = 1'b0;

  // Response monitor and scoreboard pop.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_v) chk("busy_drop", 32'(busy_m), 32'(|rdy_m));
      prev_v = vld_m;
      if (rdy_m != 2'b00) begin
        chk("rdy_onehot", 32'($countones(rdy_m)), 32'd1);
        chk("busy_acc", 32'(busy_m), 32'd1);
        t_acc = cyc;
        rdy_cnt[rdy_m[1]]++;
        gnt_log.push_back(rdy_m[1]);
      end
      if (vld_m) begin
        n_rsp++;
        chk("busy_rsp", 32'(busy_m), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_spurious: got id %0d, want none", id_m);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(id_m), 32'(e.id));
          chk("rsp_rdata", 32'(rd_m), 32'(e.rdata));
          chk("rsp_nack", 32'(nk_m), 32'(e.nack));
          chk("rsp_lat", 32'(cyc - t_acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rsp_timeout: got %0d pending, want 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive_req(input bit id, input bit [6:0] addr,
                           input bit rw, input bit [7:0] wd);
    bit         got = 1'b0;
    logic [1:0] seen = 2'b00;
    raddr = '0;
    rrw   = 2'b00;
    rwd   = '0;
    if (id) begin
      raddr[13:7] = addr; rrw[1] = rw; rwd[15:8] = wd;
    end else begin
      raddr[6:0] = addr; rrw[0] = rw; rwd[7:0] = wd;
    end
    @(posedge clk);
    #1;
    rvld[id] = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got  = (rdy_m != 2'b00);
      seen = rdy_m;
    end
    chk("rdy_id", 32'(seen), id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    rvld = 2'b00;
  endtask

  task automatic apply_vec(input vec_t v);
    int         q;
    logic [8:0] b;
    q   = sel ? QB : QA;
    mem = v.mem;
    bus_q.delete();
    exp_q.push_back('{v.id, v.e_rdata, v.e_nack, v.qtrs * q + 1});
    drive_req(v.id, v.addr, v.rw, v.wdata);
    wait_rsp(90 * q + 20);
    repeat (2) @(negedge clk);
    chk("bus_nbytes", 32'(bus_q.size()), v.e_aack ? 32'd1 : 32'd2);
    if (bus_q.size() > 0) begin
      b = bus_q.pop_front();
      chk("bus_addr", 32'(b), 32'({v.e_abyte, v.e_aack}));
    end
    if (!v.e_aack && bus_q.size() > 0) begin
      b = bus_q.pop_front();
      chk("bus_data", 32'(b), 32'({v.e_dbyte, v.e_dack}));
    end
    if (!v.rw && !v.e_aack) chk("slave_data", 32'(curr_data), 32'(v.wdata));
  endtask

  bit pred [$];
  bit lg;
  int n_rsp0;

  initial begin
    vecs[0] = '{1'b0, 7'h27, 1'b0, 8'hA5, 8'h00,
                8'h00, 1'b0, 8'h4E, 1'b0, 8'hA5, 1'b0, 80};
    vecs[1] = '{1'b1, 7'h27, 1'b1, 8'h00, 8'h3C,
                8'h3C, 1'b0, 8'h4F, 1'b0, 8'h3C, 1'b1, 80};
    vecs[2] = '{1'b0, 7'h11, 1'b0, 8'h55, 8'h00,
                8'h00, 1'b1, 8'h22, 1'b1, 8'h00, 1'b0, 44};
    vecs[3] = '{1'b1, 7'h27, 1'b0, 8'h81, 8'h00,
                8'h00, 1'b0, 8'h4E, 1'b0, 8'h81, 1'b0, 80};
    vecs[4] = '{1'b0, 7'h27, 1'b1, 8'hFF, 8'hC6,
                8'hC6, 1'b0, 8'h4F, 1'b0, 8'hC6, 1'b1, 80};
    vecs[5] = '{1'b1, 7'h11, 1'b1, 8'h00, 8'h99,
                8'h00, 1'b1, 8'h23, 1'b1, 8'h00, 1'b0, 44};
    vecs[6] = '{1'b0, 7'h27, 1'b0, 8'h00, 8'h00,
                8'h00, 1'b0, 8'h4E, 1'b0, 8'h00, 1'b0, 80};
    vecs[7] = '{1'b1, 7'h27, 1'b1, 8'h00, 8'hFF,
                8'hFF, 1'b0, 8'h4F, 1'b0, 8'hFF, 1'b1, 80};
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;

    // Reset state, with both requests already pending.
    rvld  = 2'b11;
    raddr = {7'h27, 7'h27};
    rrw   = 2'b00;
    rwd   = {8'h34, 8'h12};
    repeat (3) @(negedge clk);
    chk("rst0_scl", 32'(scl_a), 32'd1);
    chk("rst0_sda", 32'(sda), 32'd1);
    chk("rst0_busy", 32'(busy_a), 32'd0);
    chk("rst0_ready", 32'(rdy_a), 32'd0);
    chk("rst0_valid", 32'(vld_a), 32'd0);
    chk("rst0_id", 32'(id_a), 32'd0);
    chk("rst0_rdata", 32'(rd_a), 32'd0);
    chk("rst0_nack", 32'(nk_a), 32'd0);

    // Round-robin from reset: predicted 0,1,0,1.
    lg = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lg = !lg;
      pred.push_back(lg);
      exp_q.push_back('{lg, 8'h00, 1'b0, 80 * QA + 1});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4 * (80 * QA + 10) && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
      if (rdy_cnt[0] + rdy_cnt[1] >= 4) rvld = 2'b00;
    end
    wait_rsp(10);
    chk("arb_cnt0", 32'(rdy_cnt[0]), 32'd2);
    chk("arb_cnt1", 32'(rdy_cnt[1]), 32'd2);
    for (int k = 0; k < 4; k++) begin
      if (gnt_log.size() > 0) chk("arb_order", 32'(gnt_log.pop_front()),
                                  32'(pred[k]));
    end
    chk("arb_slave", 32'(curr_data), 32'h34);

    // Table of single transactions.
    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Reset in DATA bit 3, quarter 0 (master driving sda low).
    mem    = 8'h00;
    n_rsp0 = n_rsp;
    drive_req(1'b0, 7'h27, 1'b0, 8'h42);
    repeat (52 * QA + 1) @(posedge clk);
    #1;
    chk("pre_rst_scl", 32'(scl_a), 32'd0);
    chk("pre_rst_sda", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", 32'(scl_a), 32'd1);
    chk("mid_rst_sda", 32'(sda), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid_rst_norsp", 32'(n_rsp - n_rsp0), 32'd0);
    apply_vec(vecs[3]);

    // Same write on the QTR_CYC=2 instance.
    sel = 1'b1;
    repeat (4) @(negedge clk);
    apply_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_arb.md
Name: i2c_master_arb

Overview:
Clocked single-byte I2C master that shares one bus between two on-chip requesters.
- Each transaction is a START, a 7-bit address plus R/W, one data byte, and a STOP.
- Targets the team's I2C IO-extender slave and other fixed-address slaves on the same SCL/SDA pair.
- Arbitrates round-robin between requesters, runs the bus protocol from a quarter-period tick, and returns read data and an ACK/NACK status per transaction.

Parameters:
- QTR_CYC, 125, clk cycles per quarter SCL period (100 kHz SCL at 50 MHz clk); must be >= 2.
- CNT_W, 8, width of the quarter counter; must hold QTR_CYC-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- scl  output  1  I2C clock, push-pull; no clock stretching is supported.
- sda  inout  1  I2C data, open-drain: drives 0 or releases to z.
- req_valid  input  2  per-requester transaction request; held until accepted.
- req_ready  output  2  one-cycle accept pulse, one-hot.
- req_addr  input  14  {req1 addr[6:0], req0 addr[6:0]}.
- req_rw  input  2  per requester: 1 = read, 0 = write.
- req_wdata  input  16  {req1 byte, req0 byte}; ignored on reads.
- busy  output  1  high from accept until rsp_valid, inclusive.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_id  output  1  requester that owns this response.
- rsp_rdata  output  8  read byte; 0x00 on writes or on address NACK.
- rsp_nack  output  1  1 if the address or write-data byte was NACKed.

Behaviour:
- Reset values (asynchronous, immediate):
  - scl=1, sda released, busy=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_nack=0.
  - state=IDLE, last_grant=1, so req0 wins the first tie.
- Reset mid-transfer: abort, with no response pulse and no recovery STOP. The bus may see a spurious STOP edge; this is acceptable.
- Tick: a counter runs only outside IDLE and pulses qtick every QTR_CYC clk cycles. The quarter index q0..q3 advances on qtick.
- Arbitration (IDLE only):
  - If exactly one req_valid bit is set, grant it.
  - If both are set, grant the requester that is not last_grant.
  - On grant: pulse req_ready for one cycle, capture addr/rw/wdata, set last_grant, set busy, enter START at q0.
- Frame shapes, 4 quarters each, as (sda, scl):
  - START: (1,1) (1,1) (0,1) (0,0).
  - Data/ACK bit: q0 drive sda with scl=0; q1 and q2 scl=1; q3 scl=0.
  - Sample sda on the last clk of q1.
  - STOP: (0,0) (0,1) (1,1) (1,1).
- State machine:
  - IDLE -> START -> ADDR (8 bits, MSB first: addr[6:0], then rw) -> AACK.
  - AACK: master releases sda.
    - Sampled 1: set nack and go to STOP.
    - Sampled 0: go to DATA.
  - DATA, write: shift wdata out MSB first.
  - DATA, read: release sda and shift the sampled bits into rdata MSB first.
  - DACK, write: release sda; a sampled 1 sets nack.
  - DACK, read: master releases sda (NACK, single byte), then goes to STOP.
  - STOP -> RESP -> IDLE.
- RESP lasts one clk:
  - rsp_valid=1; rsp_id, rsp_rdata and rsp_nack are valid and held until the next RESP.
  - busy is high during RESP and drops the following cycle.
- Latency: 80 quarters (START 4 + 18 bits x 4 + STOP 4). rsp_valid is asserted 80*QTR_CYC+1 clk after the req_ready cycle.
- A new grant can occur on the cycle after RESP, so back-to-back transfers have one idle clk between STOP and the next START.
- Bit counter: 3 bits, wraps 7 -> 0 to leave ADDR/DATA. No other arithmetic beyond counter wrap.

Decomposition:
- Package i2c_master_pkg holds:
  - state enum: IDLE, START, ADDR, AACK, DATA, DACK, STOP, RESP.
  - quarter-index constants Q0..Q3.
  - the START/STOP (sda, scl) pattern constants.
- Sub-module i2c_qtick: parameterised QTR_CYC counter with enable, qtick output and 2-bit quarter index.

Test Plan:
- Write: req0 addr=0x27, rw=0, wdata=0xA5, with the IO-extender slave model at 0x27 -> bus carries START, 0x4E, ACK, 0xA5, ACK, STOP; slave curr_data=0xA5; rsp_id=0, rsp_nack=0, rsp_rdata=0x00; rsp_valid exactly 80*QTR_CYC+1 clk after req_ready.
- Read: slave mem=0x3C, req1 addr=0x27, rw=1 -> address byte 0x4F; rsp_id=1, rsp_rdata=0x3C, rsp_nack=0; master leaves SDA high on the 9th data-phase clock.
- Address NACK: req0 addr=0x11 with no slave at 0x11 -> STOP immediately follows the address ACK slot (44 quarters total); rsp_nack=1, rsp_rdata=0x00.
- Arbitration: both req_valid high from reset -> first grant req0, then req1, then req0, alternating; each requester gets exactly one req_ready per accepted transfer.
- Reset mid-transfer: assert rst_n=0 during DATA bit 3 -> scl=1 and sda=z within the same cycle; no rsp_valid; the next request after release completes normally.
- QTR_CYC=2: repeat the write scenario -> identical bus bit sequence with 161-clk latency.
